// File: rtl/cmd_frame_parser.sv
// Assembles UART bytes into SYNC/cmd/addr/data command frames and presents them as registered fields.
// Optional XOR checksum byte is enabled by defining CMD_FRAME_PARSER_CHKSUM_EN.
module cmd_frame_parser #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 400000
) (
    input  logic       clk40M,
    input  logic       nRst,
    input  logic       rxValid,
    input  logic [7:0] rxData,
    output logic       cmdUpdate,
    output logic [7:0] cmd,
    output logic [7:0] addrLsb,
    output logic [7:0] addrMsb,
    output logic [7:0] dataLsb,
    output logic [7:0] dataMsb,
    output logic       frameErr,
    output logic [7:0] errCount
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int               N_FIELDS = 5;
    localparam logic [2:0]       LAST_IDX = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
`ifdef CMD_FRAME_PARSER_CHKSUM_EN
        S_CHK     = 2'd2,
`endif
        S_ACCEPT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shadow_q [N_FIELDS];
    logic [7:0]       shadow_d [N_FIELDS];
    logic [7:0]       field_q  [N_FIELDS];
    logic [7:0]       field_d  [N_FIELDS];
    logic             cmd_update_q, cmd_update_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             in_frame;
    logic             err_event;
    logic             timeout_hit;

`ifdef CMD_FRAME_PARSER_CHKSUM_EN
    logic [7:0] shadow_xor;

    always_comb begin
        shadow_xor = 8'h00;
        for (int i = 0; i < N_FIELDS; i++) begin
            shadow_xor = shadow_xor ^ shadow_q[i];
        end
    end
`endif

    // NOTE: every signal gets a default at the top so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        field_d      = field_q;
        cmd_update_d = 1'b0;
        frame_err_d  = 1'b0;
        err_count_d  = err_count_q;
        err_event    = 1'b0;
        timeout_hit  = 1'b0;
        in_frame     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rxValid && (rxData == SYNC_BYTE)) begin
                    state_d = S_PAYLOAD;
                    idx_d   = '0;
                    cnt_d   = '0;
                end
            end

            S_PAYLOAD: begin
                in_frame = 1'b1;
                if (rxValid) begin
                    cnt_d = '0;
                    for (int i = 0; i < N_FIELDS; i++) begin
                        if (idx_q == 3'(i)) shadow_d[i] = rxData;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
`ifdef CMD_FRAME_PARSER_CHKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_ACCEPT;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

`ifdef CMD_FRAME_PARSER_CHKSUM_EN
            S_CHK: begin
                in_frame = 1'b1;
                if (rxValid) begin
                    cnt_d = '0;
                    if (rxData == shadow_xor) begin
                        state_d = S_ACCEPT;
                    end else begin
                        err_event = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
`endif

            S_ACCEPT: begin
                field_d      = shadow_q;
                cmd_update_d = 1'b1;
                idx_d        = '0;
                cnt_d        = '0;
                // A sync byte landing here opens the next frame straight away.
                if (rxValid && (rxData == SYNC_BYTE)) begin
                    state_d = S_PAYLOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase

        // A byte in the same cycle as the limit wins, so only idle cycles advance or expire the counter.
        if (in_frame && !rxValid) begin
            if (cnt_q == CNT_MAX) begin
                timeout_hit = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end

        if (timeout_hit) begin
            err_event = 1'b1;
            state_d   = S_IDLE;
            idx_d     = '0;
            cnt_d     = '0;
            for (int i = 0; i < N_FIELDS; i++) begin
                shadow_d[i] = 8'h00;
            end
        end

        if (err_event) begin
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk40M) begin
        if (!nRst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            cmd_update_q <= 1'b0;
            frame_err_q  <= 1'b0;
            err_count_q  <= 8'h00;
            // NOTE: the five-entry shadow/field arrays are plain flops, so clearing them on reset is cheap and intended.
            for (int i = 0; i < N_FIELDS; i++) begin
                shadow_q[i] <= 8'h00;
                field_q[i]  <= 8'h00;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            cmd_update_q <= cmd_update_d;
            frame_err_q  <= frame_err_d;
            err_count_q  <= err_count_d;
            shadow_q     <= shadow_d;
            field_q      <= field_d;
        end
    end

    assign cmdUpdate = cmd_update_q;
    assign frameErr  = frame_err_q;
    assign errCount  = err_count_q;
    assign cmd       = field_q[0];
    assign addrLsb   = field_q[1];
    assign addrMsb   = field_q[2];
    assign dataLsb   = field_q[3];
    assign dataMsb   = field_q[4];

endmodule
